uart_tx_line_arbiter: RTL and testbench

- Shares one UART transmitter (uart_fifo TX side: tx_byte/transmit/tx_fifo_full) between NUM_REQ vmicro16 cores.
- Each core has a private APB slave port and a private line buffer.
- Complete lines (terminator seen, buffer full, or explicit flush) are granted to the UART round-robin and drained whole, so console output from different cores never interleaves mid-line.

---
 rtl/uart_tx_line_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_line_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_line_arbiter.sv
// Shares one UART TX FIFO between NUM_REQ APB-attached cores. Each core fills a private
// line buffer; complete lines are granted round-robin and drained whole, never interleaved.
module uart_tx_line_arbiter #(
    parameter int          NUM_REQ    = 4,
    parameter int          BUS_WIDTH  = 16,
    parameter int          LINE_DEPTH = 16,
    parameter logic [7:0]  LINE_TERM  = 8'h0A,
    localparam int         GW         = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             S_PSELx,
    input  logic [NUM_REQ-1:0]             S_PENABLE,
    input  logic [NUM_REQ-1:0]             S_PWRITE,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   S_PWDATA,
    output logic [NUM_REQ*BUS_WIDTH-1:0]   S_PRDATA,
    output logic [NUM_REQ-1:0]             S_PREADY,
    output logic [7:0]                     tx_byte,
    output logic                           transmit,
    input  logic                           tx_fifo_full,
    output logic [GW-1:0]                  grant_id,
    output logic                           busy
);

    localparam int AW = $clog2(LINE_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, DRAIN} state_e;

    state_e                      state_q, state_d;
    logic [GW-1:0]               gnt_q, gnt_d;
    logic [GW-1:0]               last_grant_q, last_grant_d;
    logic [AW-1:0]               rd_q, rd_d;
    logic [NUM_REQ-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [NUM_REQ-1:0]          locked_q, locked_d;

    logic [NUM_REQ-1:0]          byte_wr, flush_wr;
    logic [NUM_REQ-1:0][7:0]     wr_byte;
    logic [NUM_REQ-1:0][7:0]     head;
    logic                        drain_done, last_byte, found;
    logic [GW-1:0]               pick, sidx;
    logic [GW:0]                 scan;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_core
        logic [BUS_WIDTH-1:0] wdata;
        logic                 sel;
        logic [7:0]           mem [LINE_DEPTH];
        logic                 unused_wdata;

        assign wdata        = S_PWDATA[i*BUS_WIDTH +: BUS_WIDTH];
        assign sel          = S_PSELx[i] & S_PENABLE[i];
        assign wr_byte[i]   = wdata[7:0];
        assign byte_wr[i]   = sel & S_PWRITE[i] & ~locked_q[i] & ~wdata[8];
        assign flush_wr[i]  = sel & S_PWRITE[i] & ~locked_q[i] & wdata[8] & (cnt_q[i] != '0);
        // A locked core stalls writes until its line has been drained.
        assign S_PREADY[i]  = sel & (~S_PWRITE[i] | ~locked_q[i]);
        assign S_PRDATA[i*BUS_WIDTH +: BUS_WIDTH] = (sel & ~S_PWRITE[i]) ?
            {locked_q[i], {(BUS_WIDTH-1-CW){1'b0}}, cnt_q[i]} : '0;
        assign unused_wdata = ^wdata[BUS_WIDTH-1:9];

        always_ff @(posedge clk) begin
            if (byte_wr[i]) mem[cnt_q[i][AW-1:0]] <= wr_byte[i];
        end
        assign head[i] = mem[rd_q];
    end

    // Round-robin pick: first locked core after last_grant, wrapping.
    always_comb begin
        pick  = gnt_q;
        found = 1'b0;
        scan  = '0;
        sidx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = {1'b0, last_grant_q} + (GW+1)'(k);
            if (scan >= (GW+1)'(NUM_REQ)) scan = scan - (GW+1)'(NUM_REQ);
            sidx = scan[GW-1:0];
            if (!found && locked_q[sidx]) begin
                found = 1'b1;
                pick  = sidx;
            end
        end
    end

    assign last_byte = ({1'b0, rd_q} == (cnt_q[gnt_q] - CW'(1)));

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rd_d         = rd_q;
        last_grant_d = last_grant_q;
        transmit     = 1'b0;
        drain_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|locked_q) begin
                    gnt_d   = pick;
                    rd_d    = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                transmit = ~tx_fifo_full;
                if (transmit) begin
                    if (last_byte) begin
                        drain_done   = 1'b1;
                        last_grant_d = gnt_q;
                        state_d      = IDLE;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        locked_d = locked_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (drain_done && gnt_q == GW'(i)) begin
                cnt_d[i]    = '0;
                locked_d[i] = 1'b0;
            end else if (byte_wr[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
                if (wr_byte[i] == LINE_TERM || cnt_q[i] + 1'b1 == CW'(LINE_DEPTH))
                    locked_d[i] = 1'b1;
            end else if (flush_wr[i]) begin
                locked_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            last_grant_q <= GW'(NUM_REQ-1);
            rd_q         <= '0;
            cnt_q        <= '0;
            locked_q     <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            locked_q     <= locked_d;
        end
    end

    assign tx_byte  = head[gnt_q];
    assign grant_id = gnt_q;
    assign busy     = (state_q == DRAIN);

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Directed bench for uart_tx_line_arbiter: line assembly, round-robin drain order,
// stall on locked lines, FIFO back-pressure, flush and mid-drain reset.
module tb_uart_tx_line_arbiter;
    localparam int N  = 4;
    localparam int BW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    psel, penable, pwrite, pready;
    logic [N*BW-1:0] pwdata, prdata;
    logic [7:0]      tx_byte;
    logic            transmit, tx_fifo_full, busy;
    logic [1:0]      grant_id;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] txq[$];
    int         txc[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (transmit === 1'b1) begin
            txq.push_back(tx_byte);
            txc.push_back(cyc);
        end
    end

    uart_tx_line_arbiter #(
        .NUM_REQ(N), .BUS_WIDTH(BW), .LINE_DEPTH(16), .LINE_TERM(8'h0A)
    ) dut (
        .clk(clk), .reset(reset),
        .S_PSELx(psel), .S_PENABLE(penable), .S_PWRITE(pwrite),
        .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
        .tx_byte(tx_byte), .transmit(transmit), .tx_fifo_full(tx_fifo_full),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One APB access cycle on the cores in m; samples ready/rdata mid-cycle.
    task automatic apb(input logic [N-1:0] m, input logic wr, input logic [N*BW-1:0] d,
                       output logic [N-1:0] rdy, output logic [N*BW-1:0] rdat);
        psel = m; penable = m; pwrite = wr ? m : '0; pwdata = d;
        #2;
        rdy  = pready;
        rdat = prdata;
        step();
        psel = '0; penable = '0; pwrite = '0; pwdata = '0;
    endtask

    task automatic wr(input int c, input logic [15:0] v, output logic rdy);
        logic [N-1:0]    r;
        logic [N*BW-1:0] d;
        apb(N'(1 << c), 1'b1, (N*BW)'(v) << (BW*c), r, d);
        rdy = r[c];
    endtask

    task automatic rd_status(input int c, output logic rdy, output logic [15:0] s);
        logic [N-1:0]    r;
        logic [N*BW-1:0] d;
        apb(N'(1 << c), 1'b0, '0, r, d);
        rdy = r[c];
        s   = d[BW*c +: BW];
    endtask

    // Wait for busy to rise, then count busy cycles until it falls.
    task automatic drain(input string tag, output int bcyc);
        int t;
        bcyc = 0;
        t    = 0;
        while (busy !== 1'b1 && t < 20) begin step(); t++; end
        while (busy === 1'b1 && t < 200) begin bcyc++; step(); t++; end
        chk({tag, "_bounded"}, 32'(t < 200 && bcyc > 0), 32'd1);
    endtask

    task automatic check_txq(input string tag);
        chk({tag, "_len"}, 32'(txq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i),
                (i < txq.size()) ? 32'(txq[i]) : 32'hDEAD, 32'(exp_q[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic            r;
        logic [N-1:0]    r4;
        logic [N*BW-1:0] d;
        logic [15:0]     s;
        int              b, t, stalls, lock_cyc;
        logic            all_r;

        reset = 1'b1;
        psel = '0; penable = '0; pwrite = '0; pwdata = '0; tx_fifo_full = 1'b0;
        #2 reset = 1'b0;
        #2;
        chk("rst_transmit", 32'(transmit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_prdata_nz", 32'(|prdata), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();
        apb(4'hF, 1'b0, '0, r4, d);
        chk("rst_read_rdy", 32'(r4), 32'hF);
        chk("rst_status_nz", 32'(|d), 32'd0);

        // Core 0: "Hi\n"
        txq.delete(); txc.delete();
        wr(0, 16'h0048, r); chk("t1_rdy_H", 32'(r), 32'd1);
        wr(0, 16'h0069, r);
        wr(0, 16'h000A, r); chk("t1_rdy_LF", 32'(r), 32'd1);
        lock_cyc = cyc;
        drain("t1", b);
        chk("t1_busy_cycles", 32'(b), 32'd3);
        exp_q = '{8'h48, 8'h69, 8'h0A};
        check_txq("t1_tx");
        chk("t1_latency", 32'(txc.size() > 0 && txc[0] >= lock_cyc + 1), 32'd1);

        // Cores 1 and 2 lock together: core 1 first
        txq.delete();
        apb(4'b0110, 1'b1, {16'h0, 16'h0032, 16'h0031, 16'h0}, r4, d);
        chk("t2_rdy", 32'(r4), 32'h6);
        apb(4'b0110, 1'b1, {16'h0, 16'h000A, 16'h000A, 16'h0}, r4, d);
        drain("t2a_first", b);  chk("t2a_busy1", 32'(b), 32'd2);
        drain("t2a_second", b); chk("t2a_busy2", 32'(b), 32'd2);
        exp_q = '{8'h31, 8'h0A, 8'h32, 8'h0A};
        check_txq("t2a_tx");

        // Core 1 alone, then 1 and 2 together with last_grant=1: core 2 first
        txq.delete();
        wr(1, 16'h0061, r); wr(1, 16'h000A, r);
        drain("t2b_solo", b);
        apb(4'b0110, 1'b1, {16'h0, 16'h0063, 16'h0062, 16'h0}, r4, d);
        apb(4'b0110, 1'b1, {16'h0, 16'h000A, 16'h000A, 16'h0}, r4, d);
        drain("t2b_first", b);
        drain("t2b_second", b);
        exp_q = '{8'h61, 8'h0A, 8'h63, 8'h0A, 8'h62, 8'h0A};
        check_txq("t2b_tx");
        chk("t2b_grant_id", 32'(grant_id), 32'd1);

        // Core 3 fills its buffer; 17th write stalls until the drain finishes
        txq.delete();
        all_r = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wr(3, 16'(16'h40 + k), r);
            all_r = all_r & r;
        end
        chk("t3_rdy16", 32'(all_r), 32'd1);
        stalls = 0;
        r = 1'b0;
        while (!r && stalls < 100) begin
            wr(3, 16'h0050, r);
            if (!r) stalls++;
        end
        chk("t3_stall_cycles", 32'(stalls), 32'd17);
        rd_status(3, r, s);
        chk("t3_status_rdy", 32'(r), 32'd1);
        chk("t3_status", 32'(s), 32'h0001);
        wr(3, 16'h0100, r);
        chk("t3_flush_rdy", 32'(r), 32'd1);
        drain("t3_tail", b);
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h40 + k));
        exp_q.push_back(8'h50);
        check_txq("t3_tx");

        // FIFO full for 5 cycles mid-drain
        txq.delete();
        wr(0, 16'h0011, r); wr(0, 16'h0022, r); wr(0, 16'h0033, r);
        wr(0, 16'h0044, r); wr(0, 16'h000A, r);
        t = 0;
        while (busy !== 1'b1 && t < 20) begin step(); t++; end
        chk("t4_start", 32'(busy), 32'd1);
        chk("t4_first", 32'({transmit, tx_byte}), 32'h111);
        step();
        tx_fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk($sformatf("t4_hold%0d", k), 32'({transmit, tx_byte}), 32'h022);
            step();
        end
        tx_fifo_full = 1'b0;
        drain("t4_tail", b);
        chk("t4_busy_tail", 32'(b), 32'd4);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0A};
        check_txq("t4_tx");

        // Explicit flush, then flush of an empty line
        txq.delete();
        wr(0, 16'h0041, r);
        wr(0, 16'h0100, r);
        chk("t5_flush_rdy", 32'(r), 32'd1);
        drain("t5", b);
        chk("t5_busy_cycles", 32'(b), 32'd1);
        exp_q = '{8'h41};
        check_txq("t5_tx");
        rd_status(0, r, s);
        chk("t5_status_rdy", 32'(r), 32'd1);
        chk("t5_status", 32'(s), 32'h0000);
        txq.delete();
        wr(0, 16'h0100, r);
        chk("t5_empty_flush_rdy", 32'(r), 32'd1);
        repeat (10) step();
        chk("t5_no_tx", 32'(txq.size()), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);

        // Reset while byte 2 of a 5-byte line is on the bus
        txq.delete();
        wr(2, 16'h0071, r); wr(2, 16'h0072, r); wr(2, 16'h0073, r);
        wr(2, 16'h0074, r); wr(2, 16'h000A, r);
        t = 0;
        while (busy !== 1'b1 && t < 20) begin step(); t++; end
        step();
        chk("t6_pre", 32'({transmit, tx_byte}), 32'h172);
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_tx_busy", 32'({transmit, busy}), 32'd0);
        chk("t6_rst_grant", 32'(grant_id), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        rd_status(2, r, s);
        chk("t6_status_rdy", 32'(r), 32'd1);
        chk("t6_status", 32'(s), 32'h0000);
        repeat (20) step();
        exp_q = '{8'h71};
        check_txq("t6_tx");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
